// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
//   Bundles the request/response signals between the CPU control unit and the
//   sequential ALU, so both sides share one definition of the handshake.
//
//   Request (control unit -> ALU):
//     start     request strobe; the ALU samples it only while idle
//     AluOP     4-bit operation code, captured together with start
//     X, Y      operands, captured together with start
//   Response (ALU -> control unit):
//     Result    primary result (low product / quotient)
//     Result_2  secondary result (high product / remainder), 0 otherwise
//     Equal     X==Y of the captured operands
//     LESS      signed (op 11) / unsigned (op 12) X<Y, 0 for other ops
//     NOTLESS   ~LESS
//     busy      high while an operation is in flight
//     done      one-cycle pulse; the response is valid from this cycle on
//
//   Modports: master = control unit side, slave = ALU side.
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       AluOP;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result_2;
  logic             Equal;
  logic             LESS;
  logic             NOTLESS;
  logic             busy;
  logic             done;

  modport master (
    output start, AluOP, X, Y,
    input  Result, Result_2, Equal, LESS, NOTLESS, busy, done
  );

  modport slave (
    input  start, AluOP, X, Y,
    output Result, Result_2, Equal, LESS, NOTLESS, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Clocked, parametrised datapath ALU with a start/busy/done handshake.
//   Single-cycle operations finish one cycle after the request is sampled;
//   MUL (op 3) and DIVU (op 4) iterate one radix-2 step per cycle and finish
//   WIDTH+1 cycles after the request is sampled. All outputs are registered
//   and hold their previous values until the next done pulse.
//
//   Opcodes:
//     0 SLL   1 SRA   2 SRL   (shift amount = Y[SHW-1:0])
//     3 MUL   4 DIVU
//     5 ADD   6 SUB
//     7 AND   8 OR    9 XOR  10 NOR
//    11 SLT  12 SLTU  13..15 -> Result = 0
//
//   Parameters:
//     WIDTH  operand/result width, power of two in 8..64
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_seq_if.slave; request/response bundle (see alu_seq_if)
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);
  // Counter must be able to hold the value WIDTH itself.
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t             state;
  logic [3:0]         op;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               is_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;

  logic [SHW-1:0]     shamt;
  logic               lt_s;
  logic               lt_u;
  logic               less_val;
  logic [WIDTH-1:0]   res_val;
  logic [WIDTH-1:0]   res2_val;

  assign is_iter = (bus.AluOP == OP_MUL) || (bus.AluOP == OP_DIVU);

  // One radix-2 iteration on the shared accumulator {hi, lo}.
  // MUL: lo holds the remaining multiplier bits, hi the running partial sum;
  //      add Y when the current multiplier bit is set, then shift right with
  //      the add carry entering at the top.
  // DIVU: hi is the partial remainder, lo the dividend being shifted out and
  //      the quotient being shifted in. A trial subtraction that does not
  //      borrow is kept and records a 1. With Y=0 every trial succeeds, which
  //      naturally yields quotient = all ones and remainder = X.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opb};
    acc_next  = acc;
    if (op == OP_MUL) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  // Result selection from the captured operands (and the finished
  // accumulator for the iterative ops).
  always_comb begin
    shamt    = opb[SHW-1:0];
    lt_s     = $signed(opa) < $signed(opb);
    lt_u     = opa < opb;
    less_val = 1'b0;
    res2_val = '0;
    res_val  = '0;
    case (op)
      OP_SLL:  res_val = opa << shamt;
      OP_SRA:  res_val = $unsigned($signed(opa) >>> shamt);
      OP_SRL:  res_val = opa >> shamt;
      OP_MUL,
      OP_DIVU: begin
        res_val  = acc[WIDTH-1:0];
        res2_val = acc[2*WIDTH-1:WIDTH];
      end
      OP_ADD:  res_val = opa + opb;
      OP_SUB:  res_val = opa - opb;
      OP_AND:  res_val = opa & opb;
      OP_OR:   res_val = opa | opb;
      OP_XOR:  res_val = opa ^ opb;
      OP_NOR:  res_val = ~(opa | opb);
      OP_SLT: begin
        res_val  = {{(WIDTH-1){1'b0}}, lt_s};
        less_val = lt_s;
      end
      OP_SLTU: begin
        res_val  = {{(WIDTH-1){1'b0}}, lt_u};
        less_val = lt_u;
      end
      default: res_val = '0;
    endcase
  end

  // Control FSM with registered outputs. A request is only sampled in IDLE,
  // so a start held through FIN is ignored and the next one is accepted in
  // the following IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op           <= '0;
      opa          <= '0;
      opb          <= '0;
      acc          <= '0;
      cnt          <= '0;
      bus.Result   <= '0;
      bus.Result_2 <= '0;
      bus.Equal    <= 1'b0;
      bus.LESS     <= 1'b0;
      bus.NOTLESS  <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op       <= bus.AluOP;
            opa      <= bus.X;
            opb      <= bus.Y;
            bus.busy <= 1'b1;
            if (is_iter) begin
              acc   <= {{WIDTH{1'b0}}, bus.X};
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end else begin
              state <= FIN;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          bus.Result   <= res_val;
          bus.Result_2 <= res2_val;
          bus.Equal    <= (opa == opb);
          bus.LESS     <= less_val;
          bus.NOTLESS  <= ~less_val;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Scoreboard bench for alu_seq at WIDTH=32. The stimulus process pushes the
//   hand-computed response of each request into a queue; an independent
//   monitor pops an entry on every done pulse and compares the outputs, the
//   latency and the number of busy cycles.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] res2;
    logic        eq;
    logic        less;
    int          lat;
    int          issue;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycleCnt;
  int   checks;
  int   errors;
  exp_t sb[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected entry for a request that the DUT samples at the next posedge.
  task automatic pushExp(input string name, input logic [31:0] res, input logic [31:0] res2,
                         input logic eq, input logic less, input int lat);
    exp_t e;
    e.name  = name;
    e.res   = res;
    e.res2  = res2;
    e.eq    = eq;
    e.less  = less;
    e.lat   = lat;
    e.issue = cycleCnt + 1;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] res, input logic [31:0] res2,
                               input logic eq, input logic less, input int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.AluOP = op;
    bus.X     = x;
    bus.Y     = y;
    pushExp(name, res, res2, eq, less, lat);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: pending %0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  initial begin : monitor
    int   busyRun;
    exp_t e;
    busyRun = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busyRun = 0;
      end else if (bus.done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", {63'b0, bus.done}, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "/result"},   {32'b0, bus.Result},   {32'b0, e.res});
          checkOutput({e.name, "/result2"},  {32'b0, bus.Result_2}, {32'b0, e.res2});
          checkOutput({e.name, "/equal"},    {63'b0, bus.Equal},    {63'b0, e.eq});
          checkOutput({e.name, "/less"},     {63'b0, bus.LESS},     {63'b0, e.less});
          checkOutput({e.name, "/notless"},  {63'b0, bus.NOTLESS},  {63'b0, ~e.less});
          checkOutput({e.name, "/latency"},  64'(cycleCnt - e.issue), 64'(e.lat));
          checkOutput({e.name, "/busy_cyc"}, 64'(busyRun),           64'(e.lat));
        end
        busyRun = 0;
      end else if (bus.busy) begin
        busyRun++;
      end
    end
  end

  initial begin : stimulus
    int sawDone;
    cycleCnt  = 0;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.AluOP = 4'd0;
    bus.X     = '0;
    bus.Y     = '0;

    // Reset asserted between edges must take effect immediately.
    #12 rst_n = 1'b0;
    #1;
    checkOutput("rst/result",  {32'b0, bus.Result},   64'd0);
    checkOutput("rst/result2", {32'b0, bus.Result_2}, 64'd0);
    checkOutput("rst/notless", {63'b0, bus.NOTLESS},  64'd1);
    checkOutput("rst/less",    {63'b0, bus.LESS},     64'd0);
    checkOutput("rst/busy",    {63'b0, bus.busy},     64'd0);
    checkOutput("rst/done",    {63'b0, bus.done},     64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //             name    op    X             Y             Result        Result_2      Eq    Less  lat
    applyStimulus("add",  4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("sra",  4'd1,  32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("srl",  4'd2,  32'h80000000, 32'h00000024, 32'h08000000, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("sll",  4'd0,  32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("sub",  4'd6,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("and",  4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("or",   4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("xor",  4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("nor",  4'd10, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1);  waitDrain();
    applyStimulus("op13", 4'd13, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1);  waitDrain();
    applyStimulus("sltu", 4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b0, 1);  waitDrain();
    applyStimulus("slt",  4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b1, 1);  waitDrain();

    // MUL with a stray start mid-operation; outputs must keep the SLT result.
    applyStimulus("mul",  4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 33);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.AluOP = 4'd5;
    bus.X     = 32'd3;
    bus.Y     = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("mul_hold/result", {32'b0, bus.Result}, 64'd1);
    checkOutput("mul_hold/less",   {63'b0, bus.LESS},   64'd1);
    checkOutput("mul_hold/busy",   {63'b0, bus.busy},   64'd1);
    waitDrain();

    applyStimulus("divu",  4'd4, 32'd100, 32'd7, 32'd14,       32'd2, 1'b0, 1'b0, 33);  waitDrain();
    applyStimulus("div0",  4'd4, 32'd5,   32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b0, 33);  waitDrain();

    // Start held high for three edges: sampled in IDLE, ignored in FIN,
    // sampled again in the next IDLE (2-cycle issue interval).
    @(negedge clk);
    bus.start = 1'b1;
    bus.AluOP = 4'd5;
    bus.X     = 32'd1;
    bus.Y     = 32'd1;
    pushExp("b2b_first", 32'd2, 32'd0, 1'b1, 1'b0, 1);
    @(negedge clk);
    bus.X     = 32'd2;
    bus.Y     = 32'd2;
    @(negedge clk);
    bus.X     = 32'd5;
    bus.Y     = 32'd6;
    pushExp("b2b_second", 32'd11, 32'd0, 1'b0, 1'b0, 1);
    @(negedge clk);
    bus.start = 1'b0;
    waitDrain();

    // Reset 10 cycles into a MUL: no done, outputs back to reset values.
    @(negedge clk);
    bus.start = 1'b1;
    bus.AluOP = 4'd3;
    bus.X     = 32'd1234;
    bus.Y     = 32'd5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid/result",  {32'b0, bus.Result},   64'd0);
    checkOutput("rst_mid/result2", {32'b0, bus.Result_2}, 64'd0);
    checkOutput("rst_mid/equal",   {63'b0, bus.Equal},    64'd0);
    checkOutput("rst_mid/notless", {63'b0, bus.NOTLESS},  64'd1);
    checkOutput("rst_mid/busy",    {63'b0, bus.busy},     64'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) sawDone++;
    end
    checkOutput("rst_mid/no_done", 64'(sawDone), 64'd0);

    applyStimulus("add_after_rst", 4'd5, 32'd3, 32'd4, 32'd7, 32'd0, 1'b0, 1'b0, 1);
    waitDrain();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
